trap_array_block: RTL and testbench
===================================

Name: trap_array_block

Overview:
- Parametrised multi-trap successor for the main screen: NUM_TRAPS ring-shaped traps, each sweeping horizontally on its own row.
- Each trap can capture the ball, hold it for a per-second countdown, release it, then pass through an immune cooldown.
- Sits beside the ball/collision logic; the collision detector supplies per-trap hit bits, and this block returns trap geometry, draw/RGB and the capture status consumed by ball control and the HUD.

Parameters:
NUM_TRAPS, 3, number of traps (1..8)
RADIUS_OUTER, 24, ring outer radius in pixels
RADIUS_INNER, 16, ring inner radius in pixels (< RADIUS_OUTER)
X_MIN, 40, leftmost allowed centerX
X_MAX, 600, rightmost allowed centerX
Y_BASE, 120, centerY of trap 0
Y_STEP, 100, row spacing: centerY(i) = Y_BASE + i*Y_STEP
SPEED, 2, pixels moved per frame
CAPTURE_SECONDS, 5, countdown start value (1..9)
FRAMES_PER_SEC, 60, frames per countdown step
COOLDOWN_FRAMES, 120, immune frames after release
COLOR, 8'hE0, trap RGB332 colour

Ports:
clk  in  1  system clock
resetN  in  1  asynchronous active-low reset
pixelX  in  11  current scan X
pixelY  in  11  current scan Y
startOfFrame  in  1  one-cycle pulse per frame
reset_level  in  1  one-cycle synchronous level restart
pause  in  1  freeze movement, countdown and cooldown
collisionBallTrap  in  NUM_TRAPS  per-trap ball hit, bit i = trap i
RGBTrap  out  8  trap pixel colour, 8'hFF when transparent
drawTrap  out  1  current pixel lies on any trap ring (registered)
centerX  out  NUM_TRAPS*11  packed centres, trap i at [11i+10:11i]
centerY  out  NUM_TRAPS*11  packed centres
controlledByTrap  out  1  ball is held by a trap
capturedIndex  out  3  index of holding trap, 0 when none
countDownNumber  out  4  seconds remaining, 0 when none

Behaviour:
- Reset (resetN low, async) and reset_level (sync, highest priority) restore the same initial state:
  - even i: centerX = X_MIN, direction right; odd i: centerX = X_MAX, direction left.
  - all traps MOVE; controlledByTrap = 0, capturedIndex = 0, countDownNumber = 0.
  - frame counters = 0; drawTrap = 0; RGBTrap = 8'hFF.
- Per-trap FSM states: MOVE, HOLD, COOL.
- MOVE -> HOLD when collisionBallTrap[i] = 1, no trap is in HOLD, and i is the lowest asserted eligible index.
  - Same edge: controlledByTrap = 1, capturedIndex = i, countDownNumber = CAPTURE_SECONDS, second counter = 0.
  - Hits are evaluated every clock, not only on startOfFrame.
- Hits ignored for traps in COOL, and for all traps while any trap is in HOLD.
- Simultaneous hits: lowest index captures; the others stay in MOVE.
- HOLD countdown: trap is stationary.
  - On each startOfFrame with pause = 0, the second counter increments.
  - When the counter reaches FRAMES_PER_SEC-1, it clears and countDownNumber decrements.
  - A decrement from 1 to 0 releases on the same edge: controlledByTrap = 0, capturedIndex = 0, trap -> COOL, cooldown counter = COOLDOWN_FRAMES.
- COOL: moves as in MOVE. The cooldown counter decrements on each startOfFrame with pause = 0; at 0 the trap returns to MOVE.
- Movement, on startOfFrame with pause = 0, for traps in MOVE or COOL:
  - next = centerX ± SPEED.
  - If next > X_MAX: centerX = X_MAX and direction reverses; if next < X_MIN: centerX = X_MIN and direction reverses.
  - Compute in 12-bit signed to avoid underflow at small X_MIN.
- Pause: all state frozen; captures are still accepted.
- Draw is pipelined with 1-cycle latency:
  - dx = pixelX - centerX(i), dy = pixelY - centerY(i), signed 12-bit; sq = dx² + dy², 24-bit.
  - Ring hit when RADIUS_INNER² <= sq <= RADIUS_OUTER².
  - drawTrap is the registered OR of all ring hits; RGBTrap is registered COLOR when hit, else 8'hFF.
  - Both are valid the cycle after the pixel is presented.
- reset_level during HOLD drops controlledByTrap on that same edge; no COOL phase follows.

Test Plan:
- Reset then 10 frames, NUM_TRAPS = 3 -> trap0 X = 60, trap1 X = 580, trap2 X = 60; centerY = 120/220/320; controlledByTrap = 0.
- Drive trap0 toward X_MAX from X = 599 -> next frame X = 600, then 598, 596 (bounce with clamp).
- Pulse collisionBallTrap = 3'b110 -> trap1 captures: capturedIndex = 1, countDownNumber = 5; trap1 X is frozen while traps 0 and 2 keep moving.
- Hold for 300 frames -> countDownNumber steps 5,4,3,2,1 at 60-frame intervals; at frame 300, controlledByTrap = 0 and trap1 resumes moving.
- During trap1 cooldown, hit bit 1 at frame 50 -> ignored; hit bit 1 at frame 121 after release -> captured.
- Pause during HOLD for 100 frames -> countDownNumber unchanged. reset_level mid-HOLD -> all outputs return to reset values next edge.
- Pixel at distance 20 from trap0 centre -> drawTrap = 1 and RGBTrap = 8'hE0 one cycle later; distance 10 or 30 -> drawTrap = 0 and RGBTrap = 8'hFF.

Source files
------------

// File: rtl/trap_array_if.sv
// Bundle between the trap array and its surroundings: scan position, frame/level
// control and hit bits in; trap geometry, draw colour and capture status out.
interface trap_array_if #(
  parameter int NUM_TRAPS = 3
);
  logic [10:0]             pixelX;
  logic [10:0]             pixelY;
  logic                    startOfFrame;
  logic                    reset_level;
  logic                    pause;
  logic [NUM_TRAPS-1:0]    collisionBallTrap;
  logic [7:0]              RGBTrap;
  logic                    drawTrap;
  logic [NUM_TRAPS*11-1:0] centerX;
  logic [NUM_TRAPS*11-1:0] centerY;
  logic                    controlledByTrap;
  logic [2:0]              capturedIndex;
  logic [3:0]              countDownNumber;

  modport master (
    output pixelX, pixelY, startOfFrame, reset_level, pause, collisionBallTrap,
    input  RGBTrap, drawTrap, centerX, centerY, controlledByTrap, capturedIndex,
           countDownNumber
  );

  modport slave (
    input  pixelX, pixelY, startOfFrame, reset_level, pause, collisionBallTrap,
    output RGBTrap, drawTrap, centerX, centerY, controlledByTrap, capturedIndex,
           countDownNumber
  );
endinterface

// File: rtl/trap_array_block.sv
// Row of ring-shaped traps sweeping horizontally; one trap at a time may hold the
// ball for a seconds countdown, then stays immune for a cooldown while moving.
module trap_array_block #(
  parameter int          NUM_TRAPS       = 3,
  parameter int          RADIUS_OUTER    = 24,
  parameter int          RADIUS_INNER    = 16,
  parameter int          X_MIN           = 40,
  parameter int          X_MAX           = 600,
  parameter int          Y_BASE          = 120,
  parameter int          Y_STEP          = 100,
  parameter int          SPEED           = 2,
  parameter int          CAPTURE_SECONDS = 5,
  parameter int          FRAMES_PER_SEC  = 60,
  parameter int          COOLDOWN_FRAMES = 120,
  parameter logic [7:0]  COLOR           = 8'hE0
) (
  input  logic         clk,
  input  logic         resetN,
  trap_array_if.slave  bus
);

  localparam int CW = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
  localparam int SW = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
  localparam logic signed [11:0] XMIN_S  = 12'(X_MIN);
  localparam logic signed [11:0] XMAX_S  = 12'(X_MAX);
  localparam logic signed [11:0] SPEED_S = 12'(SPEED);
  localparam logic [23:0] RIN_SQ  = 24'(RADIUS_INNER * RADIUS_INNER);
  localparam logic [23:0] ROUT_SQ = 24'(RADIUS_OUTER * RADIUS_OUTER);

  typedef enum logic [1:0] {MOVE, HOLD, COOL} trap_state_t;

  logic                 tick;
  logic                 any_hold;
  logic                 sec_wrap;
  logic                 release_now;
  logic [NUM_TRAPS-1:0] is_move;
  logic [NUM_TRAPS-1:0] is_hold;
  logic [NUM_TRAPS-1:0] eligible;
  logic [NUM_TRAPS-1:0] grant;
  logic [NUM_TRAPS-1:0] ring_hit;
  logic                 cap_valid;
  logic [2:0]           cap_idx;

  logic          controlled, controlled_n;
  logic [2:0]    held_idx, held_idx_n;
  logic [3:0]    count_down, count_down_n;
  logic [SW-1:0] sec_cnt, sec_cnt_n;
  logic          draw_q;
  logic [7:0]    rgb_q;

  assign tick     = bus.startOfFrame & ~bus.pause;
  assign any_hold = |is_hold;
  assign sec_wrap    = tick & any_hold & (sec_cnt == SW'(FRAMES_PER_SEC - 1));
  assign release_now = sec_wrap & (count_down == 4'd1);

  // Lowest eligible hit wins; all hits are ignored while any trap holds the ball.
  assign eligible  = any_hold ? '0 : (bus.collisionBallTrap & is_move);
  assign grant     = eligible & (~eligible + 1'b1);
  assign cap_valid = |grant;

  always_comb begin
    cap_idx = '0;
    for (int unsigned k = 0; k < NUM_TRAPS; k++) begin
      if (grant[k]) cap_idx = 3'(k);
    end
  end

  always_comb begin
    controlled_n = controlled;
    held_idx_n   = held_idx;
    count_down_n = count_down;
    sec_cnt_n    = sec_cnt;
    if (bus.reset_level) begin
      controlled_n = 1'b0;
      held_idx_n   = '0;
      count_down_n = '0;
      sec_cnt_n    = '0;
    end else if (cap_valid) begin
      controlled_n = 1'b1;
      held_idx_n   = cap_idx;
      count_down_n = 4'(CAPTURE_SECONDS);
      sec_cnt_n    = '0;
    end else if (any_hold && tick) begin
      if (sec_wrap) begin
        sec_cnt_n    = '0;
        count_down_n = count_down - 4'd1;
        if (release_now) begin
          controlled_n = 1'b0;
          held_idx_n   = '0;
        end
      end else begin
        sec_cnt_n = sec_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      controlled <= 1'b0;
      held_idx   <= '0;
      count_down <= '0;
      sec_cnt    <= '0;
    end else begin
      controlled <= controlled_n;
      held_idx   <= held_idx_n;
      count_down <= count_down_n;
      sec_cnt    <= sec_cnt_n;
    end
  end

  for (genvar i = 0; i < NUM_TRAPS; i++) begin : g_trap
    localparam logic [10:0]        INIT_X    = (i % 2 == 0) ? 11'(X_MIN) : 11'(X_MAX);
    localparam logic               INIT_LEFT = 1'(i % 2);
    localparam logic signed [11:0] CY        = 12'(Y_BASE + i * Y_STEP);

    trap_state_t        state, state_n;
    logic [10:0]        x, x_n;
    logic               left, left_n;
    logic [CW-1:0]      cool, cool_n;
    logic signed [11:0] nxt;
    logic [10:0]        step_x;
    logic               step_left;
    logic signed [11:0] dx, dy;
    logic signed [23:0] dx_w, dy_w;
    logic [23:0]        sq;

    assign is_move[i] = (state == MOVE);
    assign is_hold[i] = (state == HOLD);
    assign bus.centerX[11*i +: 11] = x;
    assign bus.centerY[11*i +: 11] = CY[10:0];

    // Signed 12-bit step so that X_MIN near zero clamps instead of wrapping.
    always_comb begin
      nxt       = left ? ($signed({1'b0, x}) - SPEED_S) : ($signed({1'b0, x}) + SPEED_S);
      step_x    = nxt[10:0];
      step_left = left;
      if (nxt > XMAX_S) begin
        step_x    = 11'(X_MAX);
        step_left = ~left;
      end else if (nxt < XMIN_S) begin
        step_x    = 11'(X_MIN);
        step_left = ~left;
      end
    end

    always_comb begin
      state_n = state;
      x_n     = x;
      left_n  = left;
      cool_n  = cool;
      if (bus.reset_level) begin
        state_n = MOVE;
        x_n     = INIT_X;
        left_n  = INIT_LEFT;
        cool_n  = '0;
      end else begin
        case (state)
          MOVE: begin
            if (grant[i]) begin
              state_n = HOLD;
            end else if (tick) begin
              x_n    = step_x;
              left_n = step_left;
            end
          end
          HOLD: begin
            if (release_now) begin
              state_n = COOL;
              cool_n  = CW'(COOLDOWN_FRAMES);
            end
          end
          COOL: begin
            if (tick) begin
              x_n    = step_x;
              left_n = step_left;
              if (cool > CW'(1)) begin
                cool_n = cool - 1'b1;
              end else begin
                cool_n  = '0;
                state_n = MOVE;
              end
            end
          end
          default: state_n = MOVE;
        endcase
      end
    end

    always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
        state <= MOVE;
        x     <= INIT_X;
        left  <= INIT_LEFT;
        cool  <= '0;
      end else begin
        state <= state_n;
        x     <= x_n;
        left  <= left_n;
        cool  <= cool_n;
      end
    end

    assign dx   = $signed({1'b0, bus.pixelX}) - $signed({1'b0, x});
    assign dy   = $signed({1'b0, bus.pixelY}) - CY;
    assign dx_w = 24'(dx);
    assign dy_w = 24'(dy);
    assign sq   = $unsigned(dx_w * dx_w) + $unsigned(dy_w * dy_w);
    assign ring_hit[i] = (sq >= RIN_SQ) && (sq <= ROUT_SQ);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      draw_q <= 1'b0;
      rgb_q  <= 8'hFF;
    end else if (bus.reset_level) begin
      draw_q <= 1'b0;
      rgb_q  <= 8'hFF;
    end else begin
      draw_q <= |ring_hit;
      rgb_q  <= (|ring_hit) ? COLOR : 8'hFF;
    end
  end

  assign bus.drawTrap         = draw_q;
  assign bus.RGBTrap          = rgb_q;
  assign bus.controlledByTrap = controlled;
  assign bus.capturedIndex    = held_idx;
  assign bus.countDownNumber  = count_down;

endmodule

// File: tb/tb_trap_array_block.sv
// Randomised bench for trap_array_block with a frame-level behavioural model,
// plus directed scenarios pinned by hand-computed values.
module tb_trap_array_block;
  localparam int N      = 3;
  localparam int X_MIN  = 40;
  localparam int X_MAX  = 600;
  localparam int SPEED  = 2;
  localparam int FPS    = 60;
  localparam int CAPS   = 5;
  localparam int COOLF  = 120;
  localparam int Y_BASE = 120;
  localparam int Y_STEP = 100;
  localparam int RIN    = 16;
  localparam int ROUT   = 24;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  int tests = 0;
  int fails = 0;

  trap_array_if #(.NUM_TRAPS(N)) bus ();
  trap_array_if #(.NUM_TRAPS(1)) bus2 ();

  trap_array_block #(.NUM_TRAPS(N)) dut (
    .clk(clk), .resetN(resetN), .bus(bus.slave)
  );
  trap_array_block #(.NUM_TRAPS(1), .X_MIN(39)) dut2 (
    .clk(clk), .resetN(resetN), .bus(bus2.slave)
  );

  assign bus2.pixelX            = bus.pixelX;
  assign bus2.pixelY            = bus.pixelY;
  assign bus2.startOfFrame      = bus.startOfFrame;
  assign bus2.reset_level       = bus.reset_level;
  assign bus2.pause             = bus.pause;
  assign bus2.collisionBallTrap = 1'b0;

  always #5 clk = ~clk;

  // Model state: trap positions/directions, immunity frames left, holder (-1 none).
  int mx [N];
  int mdir [N];
  int immune [N];
  int holder;
  int secs;
  int frames_in_sec;
  int exp_draw;
  int exp_rgb;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_init();
    for (int i = 0; i < N; i++) begin
      mx[i]     = (i % 2 == 0) ? X_MIN : X_MAX;
      mdir[i]   = (i % 2 == 0) ? 1 : -1;
      immune[i] = 0;
    end
    holder = -1;
    secs = 0;
    frames_in_sec = 0;
    exp_draw = 0;
    exp_rgb = 255;
  endtask

  task automatic model_step();
    int cap;
    int old_holder;
    int hit;
    hit = 0;
    for (int i = 0; i < N; i++) begin
      int dx, dy, d2;
      dx = int'(bus.pixelX) - mx[i];
      dy = int'(bus.pixelY) - (Y_BASE + i * Y_STEP);
      d2 = dx * dx + dy * dy;
      if (d2 >= RIN * RIN && d2 <= ROUT * ROUT) hit = 1;
    end
    exp_draw = hit;
    exp_rgb  = hit ? 8'hE0 : 255;

    cap = -1;
    if (holder < 0) begin
      for (int i = 0; i < N; i++) begin
        if (cap < 0 && bus.collisionBallTrap[i] && immune[i] == 0) cap = i;
      end
    end
    old_holder = holder;

    if (bus.startOfFrame && !bus.pause) begin
      if (holder >= 0) begin
        if (frames_in_sec == FPS - 1) begin
          frames_in_sec = 0;
          secs--;
          if (secs == 0) begin
            immune[holder] = COOLF;
            holder = -1;
          end
        end else begin
          frames_in_sec++;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (i != old_holder && i != cap) begin
          int nx;
          if (immune[i] > 0) immune[i]--;
          nx = mx[i] + mdir[i] * SPEED;
          if (nx > X_MAX) begin mx[i] = X_MAX; mdir[i] = -mdir[i]; end
          else if (nx < X_MIN) begin mx[i] = X_MIN; mdir[i] = -mdir[i]; end
          else mx[i] = nx;
        end
      end
    end

    if (cap >= 0) begin
      holder = cap;
      secs = CAPS;
      frames_in_sec = 0;
    end
  endtask

  always @(posedge clk or negedge resetN) begin
    if (!resetN || bus.reset_level) model_init();
    else model_step();
  end

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      check($sformatf("centerX[%0d]", i), int'(bus.centerX[11*i +: 11]), mx[i]);
      check($sformatf("centerY[%0d]", i), int'(bus.centerY[11*i +: 11]), Y_BASE + i * Y_STEP);
    end
    check("controlledByTrap", int'(bus.controlledByTrap), (holder >= 0) ? 1 : 0);
    check("capturedIndex", int'(bus.capturedIndex), (holder >= 0) ? holder : 0);
    check("countDownNumber", int'(bus.countDownNumber), (holder >= 0) ? secs : 0);
    check("drawTrap", int'(bus.drawTrap), exp_draw);
    check("RGBTrap", int'(bus.RGBTrap), exp_rgb);
  end

  task automatic frames(input int n);
    for (int k = 0; k < n; k++) begin
      bus.startOfFrame = 1'b1;
      @(negedge clk);
      bus.startOfFrame = 1'b0;
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic hit_pulse(input logic [N-1:0] bits);
    bus.collisionBallTrap = bits;
    @(negedge clk);
    bus.collisionBallTrap = '0;
  endtask

  task automatic pixel(input int px, input int py);
    bus.pixelX = 11'(px);
    bus.pixelY = 11'(py);
    @(negedge clk);
  endtask

  initial begin
    bus.pixelX = '0;
    bus.pixelY = '0;
    bus.startOfFrame = 1'b0;
    bus.reset_level = 1'b0;
    bus.pause = 1'b0;
    bus.collisionBallTrap = '0;
    model_init();
    repeat (3) @(negedge clk);
    check("reset ctrl", int'(bus.controlledByTrap), 0);
    check("reset rgb", int'(bus.RGBTrap), 255);
    check("reset x1", int'(bus.centerX[21:11]), 600);
    resetN = 1'b1;

    frames(10);
    check("10f x0", int'(bus.centerX[10:0]), 60);
    check("10f x1", int'(bus.centerX[21:11]), 580);
    check("10f x2", int'(bus.centerX[32:22]), 60);
    check("10f y2", int'(bus.centerY[32:22]), 320);

    frames(270);
    check("bounce 599", int'(bus2.centerX[10:0]), 599);
    frames(1);
    check("bounce 600", int'(bus2.centerX[10:0]), 600);
    frames(1);
    check("bounce 598", int'(bus2.centerX[10:0]), 598);
    frames(1);
    check("bounce 596", int'(bus2.centerX[10:0]), 596);
    check("283f x0", int'(bus.centerX[10:0]), 596);
    check("283f x1", int'(bus.centerX[21:11]), 44);

    hit_pulse(3'b110);
    check("cap ctrl", int'(bus.controlledByTrap), 1);
    check("cap idx", int'(bus.capturedIndex), 1);
    check("cap cd", int'(bus.countDownNumber), 5);
    frames(10);
    check("held x1", int'(bus.centerX[21:11]), 44);
    check("moving x0", int'(bus.centerX[10:0]), 576);
    frames(49);
    check("cd 59f", int'(bus.countDownNumber), 5);
    frames(1);
    check("cd 60f", int'(bus.countDownNumber), 4);

    bus.pause = 1'b1;
    frames(100);
    check("paused cd", int'(bus.countDownNumber), 4);
    bus.pause = 1'b0;
    frames(239);
    check("299f cd", int'(bus.countDownNumber), 1);
    check("299f ctrl", int'(bus.controlledByTrap), 1);
    frames(1);
    check("release ctrl", int'(bus.controlledByTrap), 0);
    check("release cd", int'(bus.countDownNumber), 0);

    frames(50);
    hit_pulse(3'b010);
    check("cool ignore", int'(bus.controlledByTrap), 0);
    frames(70);
    hit_pulse(3'b010);
    check("recapture ctrl", int'(bus.controlledByTrap), 1);
    check("recapture idx", int'(bus.capturedIndex), 1);

    frames(5);
    bus.reset_level = 1'b1;
    @(negedge clk);
    bus.reset_level = 1'b0;
    check("lvl ctrl", int'(bus.controlledByTrap), 0);
    check("lvl cd", int'(bus.countDownNumber), 0);
    check("lvl x1", int'(bus.centerX[21:11]), 600);

    pixel(60, 120);
    check("ring 20 draw", int'(bus.drawTrap), 1);
    check("ring 20 rgb", int'(bus.RGBTrap), 8'hE0);
    pixel(50, 120);
    check("ring 10 draw", int'(bus.drawTrap), 0);
    pixel(70, 120);
    check("ring 30 rgb", int'(bus.RGBTrap), 255);
    pixel(40, 104);
    check("ring 16 draw", int'(bus.drawTrap), 1);
    pixel(40, 145);
    check("ring 25 draw", int'(bus.drawTrap), 0);

    for (int cyc = 0; cyc < 24000; cyc++) begin
      int k, px, py;
      bus.startOfFrame = (cyc % 4 == 0);
      if ($urandom_range(0, 199) == 0) bus.pause = ~bus.pause;
      bus.collisionBallTrap = ($urandom_range(0, 39) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      bus.reset_level = ($urandom_range(0, 4999) == 0);
      k  = int'($urandom_range(0, N - 1));
      px = mx[k] + int'($urandom_range(0, 60)) - 30;
      py = Y_BASE + k * Y_STEP + int'($urandom_range(0, 60)) - 30;
      bus.pixelX = 11'(px);
      bus.pixelY = 11'(py);
      @(negedge clk);
    end
    bus.startOfFrame = 1'b0;
    bus.pause = 1'b0;
    bus.collisionBallTrap = '0;
    bus.reset_level = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
